// File: rtl/fir_filter.sv
// Fully parallel direct-form FIR low-pass with a triangular (Bartlett) coefficient set.
// Three register stages: delay line, tap products, rounded/saturated sum.
module fir_filter #(
    parameter int ORDER      = 31,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ena_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic signed [DATA_WIDTH-1:0] data_o
);

    localparam int N      = ORDER + 1;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(N);

    function automatic int weight(input int k);
        return (k + 1 < N - k) ? k + 1 : N - k;
    endfunction

    function automatic int weight_sum();
        int s;
        s = 0;
        for (int k = 0; k < N; k++) begin
            s += weight(k);
        end
        return s;
    endfunction

    localparam longint WSUM = longint'(weight_sum());
    localparam longint STEP = (longint'(1) << (COEF_WIDTH - 1)) / WSUM;

    function automatic logic signed [COEF_WIDTH-1:0] coef(input int k);
        return COEF_WIDTH'(longint'(weight(k)) * STEP);
    endfunction

    localparam logic signed [ACC_W:0]   RND  = (ACC_W + 1)'(longint'(1) << (COEF_WIDTH - 2));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - ACC_W'(1);

    // Round half up: bias by half an LSB of the output, then arithmetic shift.
    function automatic logic signed [ACC_W-1:0] round_acc(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = (ACC_W + 1)'(a) + RND;
        t = t >>> (COEF_WIDTH - 1);
        return ACC_W'(t);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] c;
        if (a > MAXV) begin
            c = MAXV;
        end else if (a < MINV) begin
            c = MINV;
        end else begin
            c = a;
        end
        return DATA_WIDTH'(c);
    endfunction

    logic signed [DATA_WIDTH-1:0] x_p0   [N];
    logic signed [PROD_W-1:0]     prod_c [N];
    logic signed [PROD_W-1:0]     p_p1   [N];
    logic signed [ACC_W-1:0]      acc_c;

    for (genvar k = 0; k < N; k++) begin : g_tap
        localparam logic signed [COEF_WIDTH-1:0] H = coef(k);
        assign prod_c[k] = PROD_W'(x_p0[k]) * PROD_W'(H);
    end

    always_comb begin
        acc_c = '0;
        for (int k = 0; k < N; k++) begin
            acc_c = acc_c + ACC_W'(p_p1[k]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N; k++) begin
                x_p0[k] <= '0;
                p_p1[k] <= '0;
            end
            data_o <= '0;
        end else if (ena_i) begin
            // stage 0: delay line
            x_p0[0] <= data_i;
            for (int k = 1; k < N; k++) begin
                x_p0[k] <= x_p0[k-1];
            end
            // stage 1: tap products
            for (int k = 0; k < N; k++) begin
                p_p1[k] <= prod_c[k];
            end
            // stage 2: sum, round, saturate
            data_o <= saturate(round_acc(acc_c));
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: arithmetic reference model plus directed impulse/step/stall/reset cases.
module tb_fir_filter;

    localparam int ORDER = 31;
    localparam int N     = ORDER + 1;
    localparam int DW    = 8;
    localparam int CW    = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i = 1'b0;
    logic                 ena_i = 1'b1;
    logic signed [DW-1:0] data_i = '0;
    logic signed [DW-1:0] data_o;

    int checks = 0;
    int errors = 0;

    int h_ref [N];
    int hist  [N];
    int exp_q [$];

    fir_filter #(.ORDER(ORDER), .DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ena_i (ena_i),
        .data_i(data_i),
        .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic check_true(input string name, input bit ok, input int act, input int bound);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, bound %0d", name, $time, act, bound);
        end
    endtask

    // y = sum h[k]*x[n-k], rounded half up to the output LSB and clamped to the output range.
    function automatic int model();
        longint acc;
        acc = 0;
        for (int k = 0; k < N; k++) begin
            acc += longint'(h_ref[k]) * longint'(hist[k]);
        end
        acc = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return int'(acc);
    endfunction

    task automatic drive(input logic r, input logic e, input int d);
        @(negedge clk_i);
        rst_i  = r;
        ena_i  = e;
        data_i = DW'(d);
        if (!r) begin
            exp_q.delete();
            exp_q.push_back(0);
            exp_q.push_back(0);
            for (int k = 0; k < N; k++) hist[k] = 0;
        end else if (e) begin
            for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
            exp_q.push_back(model());
        end
    endtask

    task automatic check_after(input string name, input int req);
        @(posedge clk_i);
        #1;
        check(name, int'(data_o), req);
    endtask

    // Monitor: every edge, compare data_o against reset value, held value, or scoreboard head.
    initial begin
        logic r, e;
        int prev;
        prev = 0;
        forever begin
            @(posedge clk_i);
            r = rst_i;
            e = ena_i;
            #1;
            if (!r) begin
                check("sb_reset", int'(data_o), 0);
            end else if (!e) begin
                check("sb_hold", int'(data_o), prev);
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow at %0t: got %0d, expected queued value", $time, data_o);
            end else begin
                check("sb_data", int'(data_o), exp_q.pop_front());
            end
            prev = int'(data_o);
        end
    end

    initial begin
        int s, prev_out;
        s = 0;
        for (int k = 0; k < N; k++) begin
            h_ref[k] = (k + 1 < N - k) ? k + 1 : N - k;
            s += h_ref[k];
        end
        for (int k = 0; k < N; k++) h_ref[k] = h_ref[k] * ((1 << (CW - 1)) / s);
        for (int k = 0; k < N; k++) hist[k] = 0;
        exp_q.push_back(0);
        exp_q.push_back(0);

        // Reset held with active input and enable
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 127);
            check_after("reset_hold", 0);
        end

        // Impulse
        drive(1'b1, 1'b1, 127);
        check_after("impulse_e0", 0);
        for (int e = 1; e <= 40; e++) begin
            drive(1'b1, 1'b1, 0);
            @(posedge clk_i);
            #1;
            if (e == 2) check("impulse_e2", int'(data_o), 0);
            if (e == 3) check("impulse_e3", int'(data_o), 1);
            if (e == 17 || e == 18) check("impulse_peak", int'(data_o), 7);
            if (e >= 34) check("impulse_tail", int'(data_o), 0);
        end

        // Impulse with a 10-cycle stall after edge 10
        drive(1'b0, 1'b1, 0);
        drive(1'b1, 1'b1, 127);
        for (int e = 1; e <= 40; e++) begin
            if (e == 11) begin
                for (int j = 0; j < 10; j++) drive(1'b1, 1'b0, int'($urandom_range(0, 255)) - 128);
            end
            drive(1'b1, 1'b1, 0);
            @(posedge clk_i);
            #1;
            if (e == 3) check("stall_e3", int'(data_o), 1);
            if (e == 17 || e == 18) check("stall_peak", int'(data_o), 7);
            if (e >= 34) check("stall_tail", int'(data_o), 0);
        end

        // Positive step, monotonic rise to full scale
        drive(1'b0, 1'b1, 0);
        prev_out = 0;
        for (int e = 0; e <= 40; e++) begin
            drive(1'b1, 1'b1, 127);
            @(posedge clk_i);
            #1;
            check_true("pstep_mono", int'(data_o) >= prev_out, int'(data_o), prev_out);
            if (e >= 33) check("pstep_settle", int'(data_o), 127);
            prev_out = int'(data_o);
        end

        // Negative step, must never wrap positive
        drive(1'b0, 1'b1, 0);
        for (int e = 0; e <= 40; e++) begin
            drive(1'b1, 1'b1, -128);
            @(posedge clk_i);
            #1;
            check_true("nstep_sign", int'(data_o) <= 0, int'(data_o), 0);
            if (e >= 33) check("nstep_settle", int'(data_o), -127);
        end

        // Step with a reset pulse at edge 20 (reset wins over enable)
        drive(1'b0, 1'b1, 0);
        for (int e = 0; e < 20; e++) drive(1'b1, 1'b1, 127);
        drive(1'b0, 1'b1, 127);
        check_after("midreset_zero", 0);
        for (int e = 0; e <= 40; e++) begin
            drive(1'b1, 1'b1, 127);
            @(posedge clk_i);
            #1;
            if (e <= 1) check("midreset_restart", int'(data_o), 0);
            if (e >= 33) check("midreset_settle", int'(data_o), 127);
        end

        // Randomized traffic with random stalls and occasional resets
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 8),
                  int'($urandom_range(0, 255)) - 128);
        end

        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
